// File: rtl/vid2is_resolution_detector.sv
// Measures active samples per line, active lines per field and interlace status from upstream sync flags.
// Define RES_DETECT_TOTAL_EN to add the total-samples-per-line counter (h_sync rise to h_sync rise).
module vid2is_resolution_detector #(
    parameter int H_COUNT_WIDTH = 15,
    parameter int V_COUNT_WIDTH = 13,
    parameter int STABLE_FIELDS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vid_locked,
    input  logic                     vid_enable,
    input  logic                     vid_datavalid,
    input  logic                     vid_h_sync,
    input  logic                     vid_v_sync,
    input  logic                     vid_f,
    output logic [H_COUNT_WIDTH-1:0] active_sample_count,
    output logic [V_COUNT_WIDTH-1:0] active_line_count_f0,
    output logic [V_COUNT_WIDTH-1:0] active_line_count_f1,
    output logic [H_COUNT_WIDTH-1:0] total_sample_count,
    output logic                     interlaced,
    output logic                     stable,
    output logic                     res_changed
);
    typedef enum logic [1:0] {IDLE, ALIGN, MEASURE} state_t;

    localparam logic [H_COUNT_WIDTH-1:0] H_MAX     = '1;
    localparam logic [V_COUNT_WIDTH-1:0] V_MAX     = '1;
    localparam logic [3:0]               MATCH_MAX = 4'(STABLE_FIELDS);

    state_t                     state;
    logic                       dv_q, vs_q, f_prev, first_eval, have_line, incons;
    logic [H_COUNT_WIDTH-1:0]   sample_cnt, line_len;
    logic [V_COUNT_WIDTH-1:0]   line_cnt;
    logic [3:0]                 match_cnt;

    logic                       dv_fall, vs_rise, new_il, tot_mismatch, field_mismatch, cand_incons;
    logic [H_COUNT_WIDTH-1:0]   cand_len;
    logic [V_COUNT_WIDTH-1:0]   cand_lines, pub_lines;

    assign dv_fall = vid_enable & dv_q & ~vid_datavalid;
    assign vs_rise = vid_enable & vid_v_sync & ~vs_q;

`ifdef RES_DETECT_TOTAL_EN
    logic                       hs_q, hs_rise, tot_valid;
    logic [H_COUNT_WIDTH-1:0]   tot_cnt, tot_len, cand_tot;

    assign hs_rise      = vid_enable & vid_h_sync & ~hs_q;
    assign cand_tot     = (hs_rise && tot_valid) ? tot_cnt : tot_len;
    assign tot_mismatch = (cand_tot != total_sample_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= 1'b0;
            tot_cnt   <= '0;
            tot_len   <= '0;
            tot_valid <= 1'b0;
        end else begin
            if (vid_enable) hs_q <= vid_h_sync;
            if (!vid_locked || state != MEASURE) begin
                tot_cnt   <= '0;
                tot_len   <= '0;
                tot_valid <= 1'b0;
            end else if (hs_rise) begin
                if (tot_valid) tot_len <= tot_cnt;
                tot_cnt   <= H_COUNT_WIDTH'(1);
                tot_valid <= 1'b1;
            end else if (vid_enable && tot_cnt != H_MAX) begin
                tot_cnt <= tot_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_hs;
    assign unused_hs          = vid_h_sync;
    assign tot_mismatch       = 1'b0;
    assign total_sample_count = '0;
`endif

    // Candidates include a line whose datavalid falls on the same cycle as the v_sync rise.
    always_comb begin
        cand_len    = dv_fall ? sample_cnt : line_len;
        cand_lines  = (dv_fall && line_cnt != V_MAX) ? line_cnt + 1'b1 : line_cnt;
        cand_incons = incons | (dv_fall & have_line & (sample_cnt != line_len));
        new_il      = (vid_f != f_prev);
        pub_lines   = (new_il && vid_f) ? active_line_count_f1 : active_line_count_f0;
        field_mismatch = cand_incons || (cand_lines == '0) || (cand_len != active_sample_count)
                         || (cand_lines != pub_lines) || (new_il != interlaced) || tot_mismatch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            dv_q                 <= 1'b0;
            vs_q                 <= 1'b0;
            f_prev               <= 1'b0;
            first_eval           <= 1'b1;
            have_line            <= 1'b0;
            incons               <= 1'b0;
            sample_cnt           <= '0;
            line_len             <= '0;
            line_cnt             <= '0;
            match_cnt            <= '0;
            active_sample_count  <= '0;
            active_line_count_f0 <= '0;
            active_line_count_f1 <= '0;
            interlaced           <= 1'b0;
            stable               <= 1'b0;
            res_changed          <= 1'b0;
`ifdef RES_DETECT_TOTAL_EN
            total_sample_count   <= '0;
`endif
        end else begin
            res_changed <= 1'b0;
            if (vid_enable) begin
                dv_q <= vid_datavalid;
                vs_q <= vid_v_sync;
            end
            if (!vid_locked) begin
                state      <= IDLE;
                first_eval <= 1'b1;
                have_line  <= 1'b0;
                incons     <= 1'b0;
                sample_cnt <= '0;
                line_len   <= '0;
                line_cnt   <= '0;
                match_cnt  <= '0;
                stable     <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ALIGN;
                    ALIGN: begin
                        if (vs_rise) begin
                            state      <= MEASURE;
                            f_prev     <= vid_f;
                            have_line  <= 1'b0;
                            incons     <= 1'b0;
                            sample_cnt <= '0;
                            line_len   <= '0;
                            line_cnt   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (vid_enable && vid_datavalid && sample_cnt != H_MAX)
                            sample_cnt <= sample_cnt + 1'b1;
                        if (dv_fall) begin
                            line_len   <= sample_cnt;
                            line_cnt   <= cand_lines;
                            have_line  <= 1'b1;
                            incons     <= cand_incons;
                            sample_cnt <= '0;
                        end
                        if (vs_rise) begin
                            line_cnt   <= '0;
                            have_line  <= 1'b0;
                            incons     <= 1'b0;
                            f_prev     <= vid_f;
                            first_eval <= 1'b0;
                            if (field_mismatch) begin
                                active_sample_count <= cand_len;
                                interlaced          <= new_il;
                                if (!new_il) begin
                                    active_line_count_f0 <= cand_lines;
                                    active_line_count_f1 <= '0;
                                end else if (vid_f) begin
                                    active_line_count_f1 <= cand_lines;
                                end else begin
                                    active_line_count_f0 <= cand_lines;
                                end
`ifdef RES_DETECT_TOTAL_EN
                                total_sample_count <= cand_tot;
`endif
                                match_cnt <= '0;
                                stable    <= 1'b0;
                                if (!first_eval) res_changed <= 1'b1;
                            end else begin
                                if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + 4'd1;
                                stable <= (match_cnt >= MATCH_MAX - 4'd1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vid2is_resolution_detector.sv
// Directed bench for vid2is_resolution_detector: default-size instance plus a 3-bit sample-width instance.
module tb_vid2is_resolution_detector;
    logic clk = 1'b0;
    logic rst, vid_locked, vid_enable, vid_datavalid, vid_h_sync, vid_v_sync, vid_f;
    logic [14:0] active_sample_count, total_sample_count;
    logic [12:0] active_line_count_f0, active_line_count_f1;
    logic        interlaced, stable, res_changed;
    logic [2:0]  s_active, s_total;
    logic [12:0] s_f0, s_f1;
    logic        s_il, s_stable, s_rc;

    int total = 0;
    int bad = 0;
    int rc_cnt = 0;
    int rc0;
    logic gap = 1'b0;

`ifdef RES_DETECT_TOTAL_EN
    localparam int TOT_EN = 1;
`else
    localparam int TOT_EN = 0;
`endif

    vid2is_resolution_detector dut (
        .clk(clk), .rst(rst), .vid_locked(vid_locked), .vid_enable(vid_enable),
        .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_f(vid_f),
        .active_sample_count(active_sample_count), .active_line_count_f0(active_line_count_f0),
        .active_line_count_f1(active_line_count_f1), .total_sample_count(total_sample_count),
        .interlaced(interlaced), .stable(stable), .res_changed(res_changed)
    );

    vid2is_resolution_detector #(.H_COUNT_WIDTH(3)) dut_small (
        .clk(clk), .rst(rst), .vid_locked(vid_locked), .vid_enable(vid_enable),
        .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_f(vid_f),
        .active_sample_count(s_active), .active_line_count_f0(s_f0),
        .active_line_count_f1(s_f1), .total_sample_count(s_total),
        .interlaced(s_il), .stable(s_stable), .res_changed(s_rc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (res_changed) rc_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic dv, input logic hs, input logic vs, input logic f);
        if (gap) begin
            @(negedge clk);
            vid_enable    = 1'b0;
            vid_datavalid = 1'($urandom_range(0, 1));
            vid_h_sync    = 1'($urandom_range(0, 1));
            vid_v_sync    = 1'($urandom_range(0, 1));
            vid_f         = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        vid_enable    = 1'b1;
        vid_datavalid = dv;
        vid_h_sync    = hs;
        vid_v_sync    = vs;
        vid_f         = f;
    endtask

    // Active lines (nsamp samples + 4 blanking), then 2 v-blank lines; odd_idx line gets odd_len samples.
    task automatic field(input int nlines, input int nsamp, input logic f, input int odd_idx, input int odd_len);
        int n;
        for (int l = 0; l < nlines; l++) begin
            n = (l == odd_idx) ? odd_len : nsamp;
            for (int s = 0; s < n; s++) step(1'b1, 1'b0, 1'b0, f);
            for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 1'b0, f);
        end
        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < nsamp; s++) step(1'b0, 1'b0, 1'b1, f);
            for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 1'b1, f);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vid_locked = 1'b1; vid_enable = 1'b0;
        vid_datavalid = 1'b0; vid_h_sync = 1'b0; vid_v_sync = 1'b0; vid_f = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_active", active_sample_count, 0);
        chk("rst_f0", active_line_count_f0, 0);
        chk("rst_f1", active_line_count_f1, 0);
        chk("rst_total", total_sample_count, 0);
        chk("rst_il", interlaced, 0);
        chk("rst_stable", stable, 0);
        chk("rst_rc", res_changed, 0);

        // progressive 4x8
        field(4, 8, 1'b0, -1, 0);
        field(4, 8, 1'b0, -1, 0);
        chk("prog_active", active_sample_count, 8);
        chk("prog_f0", active_line_count_f0, 4);
        chk("prog_stable1", stable, 0);
        field(4, 8, 1'b0, -1, 0);
        chk("prog_stable2", stable, 0);
        field(4, 8, 1'b0, -1, 0);
        chk("prog_stable3", stable, 1);
        chk("prog_il", interlaced, 0);
        chk("prog_f1", active_line_count_f1, 0);
        chk("prog_total", total_sample_count, 12 * TOT_EN);
        chk("prog_rc", rc_cnt, 0);

        // size change to 10 samples
        rc0 = rc_cnt;
        field(4, 10, 1'b0, -1, 0);
        chk("chg_rc", rc_cnt - rc0, 1);
        chk("chg_stable", stable, 0);
        chk("chg_active", active_sample_count, 10);
        chk("chg_total", total_sample_count, 14 * TOT_EN);
        field(4, 10, 1'b0, -1, 0);
        chk("chg_stable1", stable, 0);
        field(4, 10, 1'b0, -1, 0);
        chk("chg_stable2", stable, 1);

        // lock loss mid-field for 5 cycles
        for (int s = 0; s < 10; s++) step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vid_locked = 1'b0;
        @(negedge clk);
        chk("lock_stable", stable, 0);
        chk("lock_active", active_sample_count, 10);
        chk("lock_f0", active_line_count_f0, 4);
        repeat (4) @(negedge clk);
        vid_locked = 1'b1;
        rc0 = rc_cnt;
        field(4, 10, 1'b0, -1, 0);
        field(4, 10, 1'b0, -1, 0);
        chk("relock_rc", rc_cnt - rc0, 0);
        chk("relock_stable1", stable, 0);
        chk("relock_active", active_sample_count, 10);
        field(4, 10, 1'b0, -1, 0);
        chk("relock_stable2", stable, 1);

        // enable gating: scenario 1 with idle cycles carrying junk flags
        do_reset();
        gap = 1'b1;
        field(4, 8, 1'b0, -1, 0);
        field(4, 8, 1'b0, -1, 0);
        chk("gate_active", active_sample_count, 8);
        chk("gate_f0", active_line_count_f0, 4);
        chk("gate_total", total_sample_count, 12 * TOT_EN);
        field(4, 8, 1'b0, -1, 0);
        chk("gate_stable2", stable, 0);
        field(4, 8, 1'b0, -1, 0);
        chk("gate_stable3", stable, 1);
        chk("gate_il", interlaced, 0);
        gap = 1'b0;

        // interlaced: f0 = 3 lines, f1 = 2 lines
        do_reset();
        field(2, 8, 1'b1, -1, 0);
        field(3, 8, 1'b0, -1, 0);
        chk("il_il1", interlaced, 1);
        chk("il_f0a", active_line_count_f0, 3);
        field(2, 8, 1'b1, -1, 0);
        chk("il_f1a", active_line_count_f1, 2);
        field(3, 8, 1'b0, -1, 0);
        chk("il_stable1", stable, 0);
        field(2, 8, 1'b1, -1, 0);
        chk("il_stable2", stable, 1);
        chk("il_f0", active_line_count_f0, 3);
        chk("il_f1", active_line_count_f1, 2);
        chk("il_il", interlaced, 1);
        chk("il_active", active_sample_count, 8);

        // saturation in the 3-bit instance with 9-sample lines
        do_reset();
        field(4, 9, 1'b0, -1, 0);
        field(4, 9, 1'b0, -1, 0);
        chk("sat_small", s_active, 7);
        chk("sat_small_f0", s_f0, 4);
        chk("sat_main", active_sample_count, 9);

        // one 8-sample line among 7-sample lines: inconsistent every field
        do_reset();
        field(4, 7, 1'b0, 1, 8);
        rc0 = rc_cnt;
        field(4, 7, 1'b0, 1, 8);
        field(4, 7, 1'b0, 1, 8);
        field(4, 7, 1'b0, 1, 8);
        chk("inc_stable3", stable, 0);
        field(4, 7, 1'b0, 1, 8);
        chk("inc_stable4", stable, 0);
        chk("inc_active", active_sample_count, 7);
        chk("inc_rc", rc_cnt - rc0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
